// File: rtl/alu_sequencer.sv
// ALU instruction sequencer: accepts one 8080 ALU-group opcode per handshake and
// drives the operand-select, fetch, temp-load and execute strobes for the SAP-3 ALU.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [7:0] opcode,
    output logic       mem_req,
    input  logic       mem_ack,
    output logic       src_oe,
    output logic [2:0] src_sel,
    output logic       alu_tmp_we,
    output logic       alu_cs,
    output logic [4:0] alu_op,
    output logic       done,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPERAND,
        S_MEM,
        S_EXEC,
        S_DONE,
        S_ILL
    } state_t;

    state_t     state;
    state_t     dec_state;
    logic [4:0] dec_op;
    logic [2:0] dec_sel;
    logic [4:0] op_q;
    logic [2:0] sel_q;
    logic       mem_req_q;
    logic       src_oe_q;
    logic       tmp_we_q;
    logic       cs_q;
    logic       done_q;
    logic       ill_q;

    always_comb begin
        dec_state = S_ILL;
        dec_op    = 5'd0;
        dec_sel   = 3'd0;
        if (opcode[7:6] == 2'b10) begin
            dec_op = {2'b00, opcode[5:3]};
            if (opcode[2:0] == 3'd6) begin
                dec_state = S_MEM;
            end else begin
                dec_state = S_OPERAND;
                dec_sel   = opcode[2:0];
            end
        end else if (opcode[7:6] == 2'b11 && opcode[2:0] == 3'd6) begin
            dec_op    = {2'b00, opcode[5:3]};
            dec_state = S_MEM;
        end else begin
            case (opcode)
                8'h07: begin dec_op = 5'd8;  dec_state = S_EXEC; end
                8'h0F: begin dec_op = 5'd9;  dec_state = S_EXEC; end
                8'h17: begin dec_op = 5'd10; dec_state = S_EXEC; end
                8'h1F: begin dec_op = 5'd11; dec_state = S_EXEC; end
                8'h2F: begin dec_op = 5'd13; dec_state = S_EXEC; end
                8'h37: begin dec_op = 5'd14; dec_state = S_EXEC; end
                8'h3F: begin dec_op = 5'd15; dec_state = S_EXEC; end
                8'h3C: begin dec_op = 5'd16; dec_state = S_EXEC; end
                8'h3D: begin dec_op = 5'd17; dec_state = S_EXEC; end
                default: begin dec_op = 5'd0; dec_state = S_ILL; end
            endcase
        end
    end

    // Strobe registers are loaded with the values belonging to the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            op_q      <= 5'd0;
            sel_q     <= 3'd0;
            mem_req_q <= 1'b0;
            src_oe_q  <= 1'b0;
            tmp_we_q  <= 1'b0;
            cs_q      <= 1'b0;
            done_q    <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            sel_q     <= 3'd0;
            mem_req_q <= 1'b0;
            src_oe_q  <= 1'b0;
            tmp_we_q  <= 1'b0;
            cs_q      <= 1'b0;
            done_q    <= 1'b0;
            ill_q     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        state     <= dec_state;
                        op_q      <= dec_op;
                        sel_q     <= dec_sel;
                        src_oe_q  <= (dec_state == S_OPERAND);
                        tmp_we_q  <= (dec_state == S_OPERAND);
                        mem_req_q <= (dec_state == S_MEM);
                        cs_q      <= (dec_state == S_EXEC);
                        ill_q     <= (dec_state == S_ILL);
                    end
                end
                S_OPERAND: begin
                    state <= S_EXEC;
                    cs_q  <= 1'b1;
                end
                S_MEM: begin
                    if (mem_ack) begin
                        state <= S_EXEC;
                        cs_q  <= 1'b1;
                    end else begin
                        mem_req_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    state  <= S_DONE;
                    done_q <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    op_q  <= 5'd0;
                end
                S_ILL: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    op_q  <= 5'd0;
                end
            endcase
        end
    end

    // Every output is forced low while reset is held, even before the reset edge.
    assign op_ready   = rst & (state == S_IDLE);
    assign mem_req    = rst & mem_req_q;
    assign src_oe     = rst & src_oe_q;
    assign src_sel    = rst ? sel_q : 3'd0;
    assign alu_tmp_we = rst & (tmp_we_q | ((state == S_MEM) & mem_ack));
    assign alu_cs     = rst & cs_q;
    assign alu_op     = rst ? op_q : 5'd0;
    assign done       = rst & done_q;
    assign illegal    = rst & ill_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: the driver pushes the expected output bundle for
// every cycle it drives, and a negedge monitor pops and compares it against the DUT.
module tb_alu_sequencer;

    typedef struct packed {
        logic       ready;
        logic       mem_req;
        logic       src_oe;
        logic [2:0] sel;
        logic       tmp_we;
        logic       cs;
        logic [4:0] op;
        logic       done;
        logic       illegal;
    } outv_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [7:0] opcode = 8'h00;
    logic       mem_req;
    logic       mem_ack = 1'b0;
    logic       src_oe;
    logic [2:0] src_sel;
    logic       alu_tmp_we;
    logic       alu_cs;
    logic [4:0] alu_op;
    logic       done;
    logic       illegal;

    outv_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    ncyc = 0;

    alu_sequencer dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
        .mem_req(mem_req), .mem_ack(mem_ack), .src_oe(src_oe), .src_sel(src_sel),
        .alu_tmp_we(alu_tmp_we), .alu_cs(alu_cs), .alu_op(alu_op), .done(done),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        outv_t a;
        outv_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.ready   = op_ready;
            a.mem_req = mem_req;
            a.src_oe  = src_oe;
            a.sel     = src_sel;
            a.tmp_we  = alu_tmp_we;
            a.cs      = alu_cs;
            a.op      = alu_op;
            a.done    = done;
            a.illegal = illegal;
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle%0d outputs got=%h want=%h (ready,mreq,oe,sel,twe,cs,op,done,ill)",
                         ncyc, a, e);
            end
            ncyc++;
        end
    end

    function automatic outv_t idle_v();
        outv_t e = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    // Reference classification: 0=accumulator-only, 1=register, 2=memory/immediate, 3=illegal.
    task automatic ref_decode(input logic [7:0] opc, output int kind,
                              output logic [4:0] op, output logic [2:0] sel);
        int acc_opc [9] = '{'h07, 'h0F, 'h17, 'h1F, 'h2F, 'h37, 'h3F, 'h3C, 'h3D};
        int acc_op  [9] = '{8, 9, 10, 11, 13, 14, 15, 16, 17};
        int v = int'(opc);
        kind = 3;
        op   = 5'd0;
        sel  = 3'd0;
        if (v >= 'h80 && v <= 'hBF) begin
            op = 5'((v - 'h80) / 8);
            if (v % 8 == 6) kind = 2;
            else begin
                kind = 1;
                sel  = 3'(v % 8);
            end
        end else if (v >= 'hC0 && v % 8 == 6) begin
            op   = 5'((v - 'hC6) / 8);
            kind = 2;
        end else begin
            for (int i = 0; i < 9; i++)
                if (acc_opc[i] == v) begin
                    kind = 0;
                    op   = 5'(acc_op[i]);
                end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] opc, input logic ack,
                        input logic r, input outv_t e);
        op_valid = v;
        opcode   = opc;
        mem_ack  = ack;
        rst      = r;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Busy cycle: op_valid, opcode and mem_ack are noise the sequencer must ignore.
    task automatic busy(input outv_t e);
        step(1'($urandom), 8'($urandom), 1'($urandom), 1'b1, e);
    endtask

    // Issue one opcode from IDLE; k is the cycle in which mem_ack arrives for memory ops.
    task automatic issue(input logic [7:0] opc, input int k);
        int         kind;
        logic [4:0] op;
        logic [2:0] sel;
        outv_t      e;
        ref_decode(opc, kind, op, sel);
        step(1'b1, opc, 1'($urandom), 1'b1, idle_v());
        if (kind == 3) begin
            e = '0; e.illegal = 1'b1;
            busy(e);
        end else begin
            if (kind == 1) begin
                e = '0; e.src_oe = 1'b1; e.sel = sel; e.tmp_we = 1'b1; e.op = op;
                busy(e);
            end else if (kind == 2) begin
                for (int c = 1; c <= k; c++) begin
                    e = '0; e.mem_req = 1'b1; e.op = op; e.tmp_we = (c == k);
                    step(1'($urandom), 8'($urandom), (c == k), 1'b1, e);
                end
            end
            e = '0; e.cs = 1'b1; e.op = op;
            busy(e);
            e = '0; e.done = 1'b1; e.op = op;
            busy(e);
        end
    endtask

    initial begin
        logic [7:0] opc;
        @(posedge clk);
        #1;
        // Reset held with op_valid high: everything low, op_ready returns on release.
        step(1'b1, 8'h81, 1'b1, 1'b0, '0);
        step(1'b1, 8'h81, 1'b1, 1'b0, '0);
        issue(8'h81, 1);
        issue(8'hFE, 4);
        issue(8'h17, 1);
        issue(8'h3D, 1);
        issue(8'h37, 1);
        issue(8'h27, 1);
        issue(8'h00, 1);
        issue(8'hC6, 1);
        // ADD M with no ack, reset in cycle 2 aborts it.
        step(1'b1, 8'h86, 1'b0, 1'b1, idle_v());
        begin
            outv_t e = '0;
            e.mem_req = 1'b1;
            step(1'b0, 8'h00, 1'b0, 1'b1, e);
        end
        step(1'b1, 8'h3C, 1'b0, 1'b0, '0);
        step(1'b0, 8'h00, 1'b0, 1'b1, idle_v());
        issue(8'h3C, 1);
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 1) == 1) opc = 8'h80 + 8'($urandom_range(0, 63));
            else opc = 8'($urandom);
            repeat ($urandom_range(0, 2)) step(1'b0, 8'($urandom), 1'($urandom), 1'b1, idle_v());
            issue(opc, $urandom_range(1, 4));
        end
        step(1'b0, 8'h00, 1'b0, 1'b1, idle_v());
        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
